// File: rtl/adbg_wb_arb_pkg.sv
// Shared types and constants for the two-master debug/CPU Wishbone arbiter.
package adbg_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_DBG = 2'd1,
        GNT_CPU = 2'd2,
        TOUT    = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int GNT_DBG_IDX = 0;
    localparam int GNT_CPU_IDX = 1;

    function automatic logic cti_is_legal(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/adbg_wb_arb_watchdog.sv
// Hung-access watchdog: counts unterminated strobe cycles and flags a forced error.
module adbg_wb_arb_watchdog
    import adbg_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    output logic o_fire,
    output logic o_timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;
    logic        r_pulse;

    assign o_fire    = (TIMEOUT != 0) && i_active && (r_count == LIMIT);
    assign o_timeout = r_pulse;

    // Any termination, strobe gap or loss of grant drops i_active and restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= o_fire;
            if ((TIMEOUT != 0) && i_active && !o_fire) begin
                r_count <= r_count + 16'd1;
            end else begin
                r_count <= '0;
            end
        end
    end

endmodule

// File: rtl/adbg_wb_arbiter.sv
// Two-master Wishbone arbiter: debug BIU (master 0) and system CPU/DMA (master 1)
// share one slave port; grants are registered and held for the whole bus cycle.
module adbg_wb_arbiter
    import adbg_wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DBG_PRIORITY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    dbg_cyc_i,
    input  logic                    dbg_stb_i,
    input  logic                    dbg_we_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_sel_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_adr_i,
    input  logic [DATA_WIDTH-1:0]   dbg_dat_i,
    input  logic [2:0]              dbg_cti_i,
    input  logic [1:0]              dbg_bte_i,
    output logic [DATA_WIDTH-1:0]   dbg_dat_o,
    output logic                    dbg_ack_o,
    output logic                    dbg_err_o,

    input  logic                    cpu_cyc_i,
    input  logic                    cpu_stb_i,
    input  logic                    cpu_we_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_sel_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    input  logic [2:0]              cpu_cti_i,
    input  logic [1:0]              cpu_bte_i,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,

    output logic [1:0]              gnt_o,
    output logic                    timeout_o
);

    localparam logic OWN_DBG = 1'(GNT_DBG_IDX);
    localparam logic OWN_CPU = 1'(GNT_CPU_IDX);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_release;
    logic       w_own_cyc;
    logic       w_oth_cyc;
    logic       w_gnt_dbg;
    logic       w_gnt_cpu;
    logic       w_tout;
    logic       w_own_dbg;
    logic       w_own_cpu;
    logic       w_wd_active;
    logic       w_wd_fire;

    assign w_gnt_dbg = (r_state == GNT_DBG);
    assign w_gnt_cpu = (r_state == GNT_CPU);
    assign w_tout    = (r_state == TOUT);
    assign w_own_dbg = w_gnt_dbg || (w_tout && (r_owner == OWN_DBG));
    assign w_own_cpu = w_gnt_cpu || (w_tout && (r_owner == OWN_CPU));

    assign w_wd_active = (w_gnt_dbg || w_gnt_cpu) && wb_stb_o && !wb_ack_i && !wb_err_i;

    adbg_wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_active  (w_wd_active),
        .o_fire    (w_wd_fire),
        .o_timeout (timeout_o)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_owner <= OWN_DBG;
            r_last  <= OWN_DBG;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Release hands the bus straight to a waiting master, so there is no dead cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_release   = 1'b0;
        w_own_cyc   = (r_owner == OWN_CPU) ? cpu_cyc_i : dbg_cyc_i;
        w_oth_cyc   = (r_owner == OWN_CPU) ? dbg_cyc_i : cpu_cyc_i;

        case (r_state)
            IDLE: begin
                if (dbg_cyc_i && (!cpu_cyc_i || (DBG_PRIORITY != 0) || (r_last == OWN_CPU))) begin
                    w_state_nxt = GNT_DBG;
                    w_owner_nxt = OWN_DBG;
                end else if (cpu_cyc_i) begin
                    w_state_nxt = GNT_CPU;
                    w_owner_nxt = OWN_CPU;
                end
            end
            GNT_DBG, GNT_CPU: begin
                if (!w_own_cyc) begin
                    w_release = 1'b1;
                end else if (w_wd_fire) begin
                    w_state_nxt = TOUT;
                end
            end
            TOUT: begin
                if (w_own_cyc) begin
                    w_state_nxt = (r_owner == OWN_CPU) ? GNT_CPU : GNT_DBG;
                end else begin
                    w_release = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_release) begin
            w_last_nxt = r_owner;
            if (w_oth_cyc) begin
                w_owner_nxt = ~r_owner;
                w_state_nxt = (r_owner == OWN_CPU) ? GNT_DBG : GNT_CPU;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_sel_o  = '0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        wb_cti_o  = CTI_CLASSIC;
        wb_bte_o  = '0;
        dbg_dat_o = '0;
        dbg_ack_o = 1'b0;
        dbg_err_o = 1'b0;
        cpu_dat_o = '0;
        cpu_ack_o = 1'b0;
        cpu_err_o = 1'b0;
        gnt_o     = '0;

        if (w_own_dbg) begin
            wb_we_o  = dbg_we_i;
            wb_sel_o = dbg_sel_i;
            wb_adr_o = dbg_adr_i;
            wb_dat_o = dbg_dat_i;
            wb_cti_o = dbg_cti_i;
            wb_bte_o = dbg_bte_i;
        end else if (w_own_cpu) begin
            wb_we_o  = cpu_we_i;
            wb_sel_o = cpu_sel_i;
            wb_adr_o = cpu_adr_i;
            wb_dat_o = cpu_dat_i;
            wb_cti_o = cpu_cti_i;
            wb_bte_o = cpu_bte_i;
        end

        if (w_gnt_dbg) begin
            wb_cyc_o  = dbg_cyc_i;
            wb_stb_o  = dbg_cyc_i && dbg_stb_i;
            dbg_dat_o = wb_dat_i;
            dbg_ack_o = wb_ack_i && dbg_cyc_i;
            dbg_err_o = wb_err_i && dbg_cyc_i;
        end

        if (w_gnt_cpu) begin
            wb_cyc_o  = cpu_cyc_i;
            wb_stb_o  = cpu_cyc_i && cpu_stb_i;
            cpu_dat_o = wb_dat_i;
            cpu_ack_o = wb_ack_i && cpu_cyc_i;
            cpu_err_o = wb_err_i && cpu_cyc_i;
        end

        // The slave is cut off during the timeout cycle; only the forced error is visible.
        if (w_tout) begin
            dbg_err_o = (r_owner == OWN_DBG);
            cpu_err_o = (r_owner == OWN_CPU);
        end

        gnt_o[GNT_DBG_IDX] = w_own_dbg;
        gnt_o[GNT_CPU_IDX] = w_own_cpu;
    end

    a_gnt_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) $onehot0(gnt_o));
    a_cti_legal:  assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
                                   wb_stb_o |-> cti_is_legal(wb_cti_o));

endmodule

// File: doc/adbg_wb_arbiter.md
Name: adbg_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares a single system Wishbone slave port between two masters.
- Master 0 (dbg) is the adbg_wb_biu master of the debug Wishbone module; master 1 (cpu) is the system CPU/DMA master.
- Grants are registered and held for a full bus cycle, including incrementing bursts; a watchdog terminates hung accesses with an error.
- Sits between the debug Wishbone module, the system master and the bus interconnect, in the wb_clk_i domain.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; sel width is DATA_WIDTH/8.
- DBG_PRIORITY, 1, 1 = dbg always wins contention; 0 = round-robin.
- TIMEOUT, 255, cycles of stb without ack/err before forced error; 0 disables the watchdog; maximum 65535.

Ports:
- wb_clk_i  in  1  Wishbone clock, the only clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- dbg_cyc_i, dbg_stb_i, dbg_we_i  in  1 each  debug master control.
- dbg_sel_i  in  DATA_WIDTH/8  debug byte select.
- dbg_adr_i  in  ADDR_WIDTH  debug address.
- dbg_dat_i  in  DATA_WIDTH  debug write data.
- dbg_cti_i  in  3  debug cycle type.
- dbg_bte_i  in  2  debug burst type.
- dbg_dat_o  out  DATA_WIDTH  read data to debug master.
- dbg_ack_o, dbg_err_o  out  1 each  termination to debug master.
- cpu_*  same set, directions and widths as dbg_*  CPU master side.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to slave.
- wb_sel_o  out  DATA_WIDTH/8  to slave.
- wb_adr_o  out  ADDR_WIDTH  to slave.
- wb_dat_o  out  DATA_WIDTH  to slave.
- wb_cti_o  out  3  to slave.
- wb_bte_o  out  2  to slave.
- wb_dat_i  in  DATA_WIDTH  read data from slave.
- wb_ack_i, wb_err_i  in  1 each  termination from slave.
- gnt_o  out  2  one-hot registered grant: bit0 = dbg, bit1 = cpu.
- timeout_o  out  1  single-cycle pulse when the watchdog fires.

Behaviour:
- Reset (synchronous, wb_rst_i high at a rising edge):
  - state = IDLE, gnt_o = 00, timeout counter = 0, round-robin pointer = dbg last served.
  - All slave-side outputs and all master ack/err outputs read 0.
  - Reset mid-transfer aborts immediately; no termination is generated afterwards.
- States: IDLE, GNT_DBG, GNT_CPU, TOUT.
- IDLE:
  - wb_cyc_o = wb_stb_o = 0.
  - If exactly one cyc_i is high, go to that master's GNT state at the next edge (1-cycle grant latency).
  - If both are high: DBG_PRIORITY=1 selects GNT_DBG. DBG_PRIORITY=0 selects the master not served last.
- GNT_x:
  - Slave outputs are a combinational mux of master x's inputs.
  - wb_cyc_o = x_cyc_i, wb_stb_o = x_cyc_i & x_stb_i.
  - x_ack_o = wb_ack_i & x_cyc_i. x_err_o = wb_err_i & x_cyc_i. x_dat_o = wb_dat_i.
  - The non-granted master sees ack = err = 0 and dat = 0, and stalls.
  - The grant is held while x_cyc_i = 1, regardless of cti and of stb gaps, so bursts stay atomic.
  - When x_cyc_i = 0 at an edge: go to the other master's GNT state if its cyc_i = 1, otherwise to IDLE. There is no dead cycle between masters.
  - Update the round-robin pointer to x on release.
- Watchdog (GNT_x only, TIMEOUT > 0):
  - Counter increments each cycle wb_stb_o = 1 and wb_ack_i = wb_err_i = 0.
  - Counter clears on ack, on err, on stb low, or on leaving GNT_x.
  - When the counter equals TIMEOUT-1 with no termination that cycle, go to TOUT.
  - Counter width is 16 bits.
- TOUT (exactly one cycle):
  - wb_cyc_o = wb_stb_o = 0.
  - x_err_o = 1, x_ack_o = 0, timeout_o = 1.
  - Slave ack/err are ignored in this cycle.
  - Next state is GNT_x if x_cyc_i is still 1, else the normal release rule applies.
- A slave ack/err arriving while no master is granted, or while the granted cyc is low, is dropped.
- Simultaneous ack and err from the slave pass both through unchanged; the master resolves them.
- gnt_o reflects the registered state: 01 in GNT_DBG or TOUT-for-dbg, 10 in GNT_CPU or TOUT-for-cpu, 00 in IDLE.

Decomposition:
- Package adbg_wb_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, GNT_DBG, GNT_CPU, TOUT}.
  - Localparams for the cti codes CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111 (used for assertions only).
  - Grant index constants GNT_DBG_IDX = 0, GNT_CPU_IDX = 1.
- One sub-module: adbg_wb_arb_watchdog (counter, compare, and the timeout pulse). The mux and FSM stay in the top.

Test Plan:
- Single dbg read: dbg_cyc_i/dbg_stb_i high at cycle 0, slave acks at cycle 3 with 0xDEADBEEF → gnt_o = 01 at cycle 1, wb_adr_o = dbg_adr_i, dbg_dat_o = 0xDEADBEEF with dbg_ack_o at cycle 3, cpu_ack_o stays 0.
- Contention, DBG_PRIORITY=1: both cyc high in IDLE → GNT_DBG. After dbg drops cyc → GNT_CPU at the very next edge with no IDLE cycle.
- Round-robin, DBG_PRIORITY=0: both masters request continuously, each doing 1-beat cycles → grants alternate dbg, cpu, dbg, cpu.
- Burst atomicity: cpu 4-beat incrementing burst (cti 010, 010, 010, 111) with dbg requesting mid-burst → gnt_o stays 10 for all 4 acks; dbg is granted only after cpu_cyc_i falls.
- Timeout, TIMEOUT=8: dbg stb held with no ack → timeout_o and dbg_err_o pulse once 8 cycles after stb with wb_cyc_o low that cycle. A late wb_ack_i is not forwarded.
- Reset mid-burst: wb_rst_i asserted during an active cpu burst → next cycle all outputs 0, gnt_o = 00, state IDLE; after release a pending dbg request is granted normally.
